// File: rtl/av2_tile_scheduler.sv
// Frame-level sequencer for the AV2 tile decoder: walks every tile of a frame in raster
// order, pulses the decoder start, streams the tile's bitstream words and waits for done.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for frame_start; frame geometry latched on accept
// START      | one-cycle decoder start pulse, word counter and watchdog cleared
// STREAM     | bs_* passed straight through to dec_* until the tile's words are sent
// WAIT_DONE  | waiting for decoder tile_done under the watchdog
// NEXT       | advance tile_index and raster coordinates
// DONE       | one-cycle frame_done, normal completion
// ERROR      | one-cycle frame_done with sticky frame_error
module av2_tile_scheduler #(
    parameter int MAX_TILE_COLS  = 8,
    parameter int MAX_TILE_ROWS  = 8,
    parameter int WORD_CNT_W     = 16,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [3:0]            tile_cols,
    input  logic [3:0]            tile_rows,
    input  logic [WORD_CNT_W-1:0] words_per_tile,
    input  logic [127:0]          bs_data,
    input  logic                  bs_valid,
    output logic                  bs_ready,
    output logic                  dec_start,
    output logic [3:0]            dec_tile_col,
    output logic [3:0]            dec_tile_row,
    output logic [127:0]          dec_data,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    input  logic                  dec_done,
    output logic                  busy,
    output logic [7:0]            tile_index,
    output logic                  frame_done,
    output logic                  frame_error
);
    localparam int              WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0]      COLS_MAX = 4'(MAX_TILE_COLS);
    localparam logic [3:0]      ROWS_MAX = 4'(MAX_TILE_ROWS);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cols;
    logic [3:0]            r_rows;
    logic [WORD_CNT_W-1:0] r_words;
    logic [3:0]            r_col;
    logic [3:0]            r_row;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic [WD_W-1:0]       r_wd;
    logic [7:0]            r_tile_index;
    logic                  r_dec_start;
    logic                  r_frame_done;
    logic                  r_frame_error;

    logic [3:0] w_cols_clamped;
    logic [3:0] w_rows_clamped;
    logic       w_beat;
    logic       w_last_word;
    logic       w_last_col;
    logic       w_last_row;
    logic       w_wd_expired;

    assign w_cols_clamped = (tile_cols > COLS_MAX) ? COLS_MAX : tile_cols;
    assign w_rows_clamped = (tile_rows > ROWS_MAX) ? ROWS_MAX : tile_rows;
    assign w_beat         = bs_valid && dec_ready;
    // Full-width compare so a count of all-ones words is still reachable.
    assign w_last_word    = (r_word_cnt == (r_words - WORD_CNT_W'(1)));
    assign w_last_col     = (r_col == (r_cols - 4'd1));
    assign w_last_row     = (r_row == (r_rows - 4'd1));
    assign w_wd_expired   = (r_wd == WD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    if ((w_cols_clamped == 4'd0) || (w_rows_clamped == 4'd0)) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                w_state_nxt = (r_words == '0) ? S_WAIT_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (dec_done) begin
                    w_state_nxt = S_ERROR;
                end else if (w_beat && w_last_word) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A done arriving on the timeout cycle still counts as success.
                if (dec_done) begin
                    w_state_nxt = S_NEXT;
                end else if (w_wd_expired) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_NEXT: begin
                w_state_nxt = (w_last_col && w_last_row) ? S_DONE : S_START;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cols        <= '0;
            r_rows        <= '0;
            r_words       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_word_cnt    <= '0;
            r_wd          <= '0;
            r_tile_index  <= '0;
            r_dec_start   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dec_start  <= (w_state_nxt == S_START);
            r_frame_done <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERROR);
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_cols        <= w_cols_clamped;
                        r_rows        <= w_rows_clamped;
                        r_words       <= words_per_tile;
                        r_col         <= '0;
                        r_row         <= '0;
                        r_tile_index  <= '0;
                        r_frame_error <= 1'b0;
                    end
                end
                S_START: begin
                    r_word_cnt <= '0;
                    r_wd       <= '0;
                end
                S_STREAM: begin
                    if (w_beat) begin
                        r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    r_wd <= r_wd + WD_W'(1);
                end
                S_NEXT: begin
                    if (r_tile_index != 8'hFF) begin
                        r_tile_index <= r_tile_index + 8'd1;
                    end
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 4'd1;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                default: ;
            endcase
            if (w_state_nxt == S_ERROR) begin
                r_frame_error <= 1'b1;
            end
        end
    end

    assign bs_ready     = (r_state == S_STREAM) ? dec_ready : 1'b0;
    assign dec_valid    = (r_state == S_STREAM) ? bs_valid : 1'b0;
    assign dec_data     = bs_data;
    assign dec_start    = r_dec_start;
    assign dec_tile_col = r_col;
    assign dec_tile_row = r_row;
    assign busy         = (r_state != S_IDLE);
    assign tile_index   = r_tile_index;
    assign frame_done   = r_frame_done;
    assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_av2_tile_scheduler.sv
// Self-checking bench for av2_tile_scheduler: a bitstream FIFO and tile decoder model
// drive the DUT while frame-level expectations come from the frame geometry alone.
module tb_av2_tile_scheduler;
    localparam int          TO   = 50;
    localparam logic [31:0] BASE = 32'h2468ACE0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic [3:0]   tile_cols = '0;
    logic [3:0]   tile_rows = '0;
    logic [15:0]  words_per_tile = '0;
    logic [127:0] bs_data = '0;
    logic         bs_valid = 1'b0;
    logic         dec_ready = 1'b0;
    logic         dec_done = 1'b0;
    logic         bs_ready, dec_start, dec_valid, busy, frame_done, frame_error;
    logic [3:0]   dec_tile_col, dec_tile_row;
    logic [127:0] dec_data;
    logic [7:0]   tile_index;

    int checks = 0;
    int errors = 0;

    int exp_words = 0;
    int done_delay = 5;
    bit done_enable = 1'b1;
    bit valid_rand = 1'b0;
    bit ready_toggle = 1'b0;

    int cyc = 0, dec_beats = 0, fifo_beats = 0, tile_beats = 0, dtimer = -1;
    int fd_count = 0, fd_cyc = 0, fd_tidx = 0, fd_err = 0;
    int start_cyc = 0, fs_cyc = 0, dd_cyc = 0, lb_cyc = 0, viol = 0;
    logic [7:0]   starts_q[$];
    logic [127:0] data_q[$];

    av2_tile_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .tile_cols(tile_cols), .tile_rows(tile_rows), .words_per_tile(words_per_tile),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .dec_start(dec_start), .dec_tile_col(dec_tile_col), .dec_tile_row(dec_tile_row),
        .dec_data(dec_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_done(dec_done), .busy(busy), .tile_index(tile_index),
        .frame_done(frame_done), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word(int m);
        logic [31:0] v;
        v = BASE + 32'(m);
        return {v, ~v, v, ~v};
    endfunction

    // FIFO + decoder model: observe mid-cycle, drive just after the rising edge.
    always begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            tile_beats = 0;
            dtimer = -1;
        end else begin
            if (frame_start) fs_cyc = cyc;
            if (dec_start) begin
                starts_q.push_back({dec_tile_row, dec_tile_col});
                start_cyc = cyc;
                tile_beats = 0;
                if (exp_words == 0) dtimer = done_delay;
            end
            if (busy && bs_ready && tile_beats >= exp_words) viol++;
            if (bs_valid && bs_ready) fifo_beats++;
            if (dec_valid && dec_ready) begin
                data_q.push_back(dec_data);
                dec_beats++;
                tile_beats++;
                lb_cyc = cyc;
                if (tile_beats == exp_words) dtimer = done_delay;
            end
            if (dec_done) dd_cyc = cyc;
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
                fd_tidx = int'(tile_index);
                fd_err = int'(frame_error);
            end
        end
        @(posedge clk);
        #1;
        bs_data = word(fifo_beats);
        bs_valid = valid_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        dec_ready = ready_toggle ? ~dec_ready : 1'b1;
        dec_done = 1'b0;
        if (dtimer > 0) begin
            dtimer--;
            if (dtimer == 0) begin
                dec_done = done_enable;
                dtimer = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk128(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(int c, int r, int w);
        tick();
        tile_cols = 4'(c);
        tile_rows = 4'(r);
        words_per_tile = 16'(w);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_fd(int fd0, int budget);
        int n;
        n = 0;
        while (fd_count == fd0 && n < budget) begin
            sample();
            n++;
        end
        repeat (3) sample();
        chk("frame_done_pulse", fd_count - fd0, 1);
    endtask

    task automatic run_frame(string tag, int c, int r, int w, int delay, bit exp_err);
        int s0, b0, f0, fd0, ec, er, n, k;
        ec = (c > 8) ? 8 : c;
        er = (r > 8) ? 8 : r;
        n = ec * er;
        done_delay = delay;
        exp_words = w;
        s0 = starts_q.size();
        b0 = dec_beats;
        f0 = fifo_beats;
        fd0 = fd_count;
        start_frame(c, r, w);
        sample();
        chk({tag, "_err_cleared"}, 32'(frame_error), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
        wait_fd(fd0, 3000);
        if (exp_err) begin
            chk({tag, "_starts"}, starts_q.size() - s0, 1);
            chk({tag, "_beats"}, dec_beats - b0, w);
            chk({tag, "_tidx"}, fd_tidx, 0);
            chk({tag, "_err"}, fd_err, 1);
        end else begin
            chk({tag, "_starts"}, starts_q.size() - s0, n);
            if (starts_q.size() - s0 == n) begin
                k = 0;
                for (int rr = 0; rr < er; rr++) begin
                    for (int cc = 0; cc < ec; cc++) begin
                        chk({tag, "_coord"}, 32'(starts_q[s0 + k]), 32'(rr * 16 + cc));
                        k++;
                    end
                end
            end
            chk({tag, "_dec_beats"}, dec_beats - b0, n * w);
            chk({tag, "_tidx"}, fd_tidx, n);
            chk({tag, "_err"}, fd_err, 0);
        end
        chk({tag, "_fifo_beats"}, fifo_beats - f0, dec_beats - b0);
        for (int m = b0; m < dec_beats; m++) chk128({tag, "_data"}, data_q[m], word(m));
        chk({tag, "_ready_outside_stream"}, viol, 0);
    endtask

    initial begin
        int s0, fd0, n;
        repeat (3) sample();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bs_ready", 32'(bs_ready), 0);
        chk("rst_dec_valid", 32'(dec_valid), 0);
        chk("rst_dec_start", 32'(dec_start), 0);
        chk("rst_tile_index", 32'(tile_index), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_error", 32'(frame_error), 0);
        chk("rst_coord", 32'({dec_tile_row, dec_tile_col}), 0);
        tick();
        rst_n = 1'b1;
        sample();
        chk("idle_busy", 32'(busy), 0);

        run_frame("nominal", 2, 2, 3, 5, 1'b0);
        chk("nominal_done_latency", fd_cyc - lb_cyc, 7);
        chk("nominal_fd_after_dd", fd_cyc - dd_cyc, 2);

        valid_rand = 1'b1;
        ready_toggle = 1'b1;
        run_frame("backpressure", 2, 1, 4, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_frame("random", $urandom_range(1, 3), $urandom_range(1, 3),
                      $urandom_range(1, 5), $urandom_range(1, 6), 1'b0);
        end
        valid_rand = 1'b0;
        ready_toggle = 1'b0;

        s0 = starts_q.size();
        fd0 = fd_count;
        exp_words = 3;
        start_frame(0, 2, 3);
        wait_fd(fd0, 20);
        chk("zero_dim_latency", 32'((fd_cyc - fs_cyc) <= 2), 1);
        chk("zero_dim_err", fd_err, 1);
        chk("zero_dim_no_start", starts_q.size() - s0, 0);
        chk("zero_dim_err_sticky", 32'(frame_error), 1);

        run_frame("words0", 1, 1, 0, 4, 1'b0);
        chk("words0_fd_after_dd", fd_cyc - dd_cyc, 2);
        chk("words0_latency", fd_cyc - start_cyc, 6);

        done_enable = 1'b0;
        run_frame("watchdog", 1, 1, 2, 5, 1'b1);
        chk("watchdog_latency", fd_cyc - start_cyc, 2 + 1 + TO);
        repeat (4) sample();
        chk("watchdog_err_sticky", 32'(frame_error), 1);
        chk("watchdog_idle", 32'(busy), 0);
        done_enable = 1'b1;
        run_frame("after_watchdog", 1, 2, 1, 2, 1'b0);

        run_frame("clamp", 12, 1, 1, 1, 1'b0);

        fd0 = fd_count;
        exp_words = 4;
        done_delay = 3;
        start_frame(2, 1, 4);
        n = 0;
        do begin
            sample();
            n++;
        end while (tile_beats != 2 && n < 50);
        chk("rst_mid_reached_beat2", tile_beats, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_bs_ready", 32'(bs_ready), 0);
        chk("rst_mid_dec_valid", 32'(dec_valid), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) sample();
        chk("rst_mid_no_frame_done", fd_count - fd0, 0);
        run_frame("post_reset", 2, 1, 4, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
